cmp_hysteresis_tracker: RTL and testbench



---
 rtl/cmp_pkg.sv | 17 +
 rtl/cmp_flag_decode.sv | 24 ++
 rtl/cmp_hysteresis_tracker.sv | 127 ++++++++++++
 tb/tb_cmp_hysteresis_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the comparator hysteresis tracker: decision states and sample classes.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_UNK  = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CLS_HOLD,
    CLS_UP,
    CLS_DOWN,
    CLS_BAD
  } sample_cls_e;

endpackage

// File: rtl/cmp_flag_decode.sv
// Maps the comparator EQ/LT/GT flags to a sample class; anything not one-hot is BAD.
module cmp_flag_decode
  import cmp_pkg::*;
(
  input  logic        valid,
  input  logic        eq,
  input  logic        lt,
  input  logic        gt,
  output logic        take,
  output sample_cls_e cls
);

  assign take = valid;

  always_comb begin
    unique case ({eq, lt, gt})
      3'b001:  cls = CLS_UP;
      3'b010:  cls = CLS_DOWN;
      3'b100:  cls = CLS_HOLD;
      default: cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/cmp_hysteresis_tracker.sv
// Debounced HIGH/LOW decision with RISE/FALL pulses, peak tracking, sticky
// error flag and a saturating transition counter, fed by the magnitude comparator.
module cmp_hysteresis_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID,
  input  logic             EQ,
  input  logic             LT,
  input  logic             GT,
  input  logic [WIDTH-1:0] A,
  output logic             HIGH,
  output logic             LOW,
  output logic             RISE,
  output logic             FALL,
  output logic [WIDTH-1:0] PEAK,
  output logic             ERR,
  output logic [CNT_W-1:0] EVT_CNT
);

  localparam int SW = $clog2(DEBOUNCE + 1);

  logic        take;
  sample_cls_e cls;

  state_e      state, state_n;
  logic [SW-1:0] streak, streak_n, inc;
  logic        dir, dir_n;    // 1 = streak counts UP samples
  logic        rise_n, fall_n;
  logic        bump;
  state_e      target;

  cmp_flag_decode u_decode (
    .valid (VALID),
    .eq    (EQ),
    .lt    (LT),
    .gt    (GT),
    .take  (take),
    .cls   (cls)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_n  = state;
    streak_n = streak;
    dir_n    = dir;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    bump     = 1'b0;
    target   = state;
    inc      = streak + 1'b1;

    if (take) begin
      unique case (state)
        ST_UNK: begin
          if (cls == CLS_UP || cls == CLS_DOWN) begin
            bump   = 1'b1;
            dir_n  = (cls == CLS_UP);
            target = (cls == CLS_UP) ? ST_HIGH : ST_LOW;
            // A reversal restarts the run at one sample in the new direction.
            if (dir != (cls == CLS_UP)) inc = SW'(1);
          end
        end
        ST_LOW: begin
          if (cls == CLS_UP) begin
            bump   = 1'b1;
            target = ST_HIGH;
          end else if (cls == CLS_DOWN) begin
            streak_n = '0;
          end
        end
        ST_HIGH: begin
          if (cls == CLS_DOWN) begin
            bump   = 1'b1;
            target = ST_LOW;
          end else if (cls == CLS_UP) begin
            streak_n = '0;
          end
        end
        default: state_n = ST_UNK;
      endcase

      if (bump) begin
        if (inc == SW'(DEBOUNCE)) begin
          state_n  = target;
          streak_n = '0;
          rise_n   = (target == ST_HIGH);
          fall_n   = (target == ST_LOW);
        end else begin
          streak_n = inc;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge; all state uses non-blocking assignment.
    if (!RST_N) begin
      state   <= ST_UNK;
      streak  <= '0;
      dir     <= 1'b0;
      RISE    <= 1'b0;
      FALL    <= 1'b0;
      PEAK    <= '0;
      ERR     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
      dir    <= dir_n;
      RISE   <= rise_n;
      FALL   <= fall_n;
      if (take && cls != CLS_BAD && A > PEAK) PEAK <= A;
      if (take && cls == CLS_BAD) ERR <= 1'b1;
      if ((rise_n || fall_n) && EVT_CNT != '1) EVT_CNT <= EVT_CNT + 1'b1;
    end
  end

  assign HIGH = (state == ST_HIGH);
  assign LOW  = (state == ST_LOW);

endmodule

// File: tb/tb_cmp_hysteresis_tracker.sv
// Directed bench: default instance for debounce/peak/error behaviour, and a
// DEBOUNCE=1, CNT_W=2 instance for immediate switching and counter saturation.
module tb_cmp_hysteresis_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, eq = 1'b0, lt = 1'b0, gt = 1'b0;
  logic [3:0] a = '0;
  logic       high, low, rise, fall, err;
  logic [3:0] peak;
  logic [7:0] evt_cnt;

  logic       valid2 = 1'b0, eq2 = 1'b0, lt2 = 1'b0, gt2 = 1'b0;
  logic [3:0] a2 = '0;
  logic       high2, low2, rise2, fall2, err2;
  logic [3:0] peak2;
  logic [1:0] evt_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmp_hysteresis_tracker #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .VALID(valid), .EQ(eq), .LT(lt), .GT(gt), .A(a),
    .HIGH(high), .LOW(low), .RISE(rise), .FALL(fall), .PEAK(peak), .ERR(err),
    .EVT_CNT(evt_cnt)
  );

  cmp_hysteresis_tracker #(.WIDTH(4), .DEBOUNCE(1), .CNT_W(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .VALID(valid2), .EQ(eq2), .LT(lt2), .GT(gt2), .A(a2),
    .HIGH(high2), .LOW(low2), .RISE(rise2), .FALL(fall2), .PEAK(peak2), .ERR(err2),
    .EVT_CNT(evt_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the main instance; outputs are settled on return.
  task automatic step(input logic r, input logic v, input logic e, input logic l,
                      input logic g, input logic [3:0] av);
    @(negedge clk);
    rst_n = r; valid = v; eq = e; lt = l; gt = g; a = av;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic l, input logic g);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0; valid2 = v; eq2 = 1'b0; lt2 = l; gt2 = g; a2 = 4'd7;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic h, input logic l,
                             input logic r, input logic f);
    check({tag, ".high"}, 32'(high), 32'(h));
    check({tag, ".low"},  32'(low),  32'(l));
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(f));
  endtask

  initial begin
    // 1. Reset dominates a valid GT sample.
    step(0, 1, 0, 0, 1, 4'd15);
    step(0, 1, 0, 0, 1, 4'd15);
    check_state("rst", 0, 0, 0, 0);
    check("rst.peak", 32'(peak), 0);
    check("rst.err",  32'(err), 0);
    check("rst.cnt",  32'(evt_cnt), 0);
    check("rst.cnt2", 32'(evt_cnt2), 0);
    step(1, 0, 0, 0, 1, 4'd15);
    step(1, 0, 0, 0, 1, 4'd15);
    check("idle.peak", 32'(peak), 0);

    // 2. Three GT samples from UNK.
    step(1, 1, 0, 0, 1, 4'd4);
    check_state("gt1", 0, 0, 0, 0);
    check("gt1.peak", 32'(peak), 4);
    step(1, 1, 0, 0, 1, 4'd5);
    check_state("gt2", 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 4'd9);
    check_state("gt3", 1, 0, 1, 0);
    check("gt3.peak", 32'(peak), 9);
    check("gt3.cnt",  32'(evt_cnt), 1);
    step(1, 0, 0, 0, 0, 4'd0);
    check_state("gt3.after", 1, 0, 0, 0);

    // 3a. LT,LT,EQ,LT switches HIGH -> LOW on the fourth sample.
    step(1, 1, 0, 1, 0, 4'd3);
    check_state("lt1", 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 4'd3);
    check_state("lt2", 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 4'd3);
    check_state("eq", 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 4'd3);
    check_state("lt3", 0, 1, 0, 1);
    check("lt3.cnt",  32'(evt_cnt), 2);
    check("lt3.peak", 32'(peak), 9);
    step(1, 0, 0, 0, 0, 4'd0);
    check_state("lt3.after", 0, 1, 0, 0);

    // 3b. GT,GT,LT,GT,GT: the LT clears the run, so no RISE.
    step(1, 1, 0, 0, 1, 4'd2);
    check_state("3b.gt1", 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 4'd2);
    check_state("3b.gt2", 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 4'd2);
    check_state("3b.lt", 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 4'd2);
    check_state("3b.gt3", 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 4'd2);
    check_state("3b.gt4", 0, 1, 0, 0);

    // 4. Illegal flags set ERR, leave PEAK and the pending streak of 2 alone.
    check("pre.err", 32'(err), 0);
    step(1, 1, 1, 0, 1, 4'd15);
    check("bad.err",  32'(err), 1);
    check("bad.peak", 32'(peak), 9);
    check_state("bad", 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 4'd15);
    check("bad0.err",  32'(err), 1);
    check("bad0.peak", 32'(peak), 9);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 4'd15);
    check_state("novalid", 0, 1, 0, 0);
    check("novalid.peak", 32'(peak), 9);
    check("novalid.err",  32'(err), 1);
    step(1, 1, 0, 0, 1, 4'd2);
    check_state("resume", 1, 0, 1, 0);
    check("resume.cnt", 32'(evt_cnt), 3);

    // 5. Reset mid-streak discards the partial run.
    step(0, 0, 0, 0, 0, 4'd0);
    check_state("r5", 0, 0, 0, 0);
    check("r5.err",  32'(err), 0);
    check("r5.cnt",  32'(evt_cnt), 0);
    check("r5.peak", 32'(peak), 0);
    step(1, 1, 0, 0, 1, 4'd1);
    step(1, 1, 0, 0, 1, 4'd1);
    step(0, 1, 0, 0, 1, 4'd1);
    step(1, 1, 0, 0, 1, 4'd1);
    step(1, 1, 0, 0, 1, 4'd1);
    check_state("r5.gt2", 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 4'd1);
    check_state("r5.gt3", 1, 0, 1, 0);

    // Direction reversal in UNK restarts the run.
    step(0, 0, 0, 0, 0, 4'd0);
    step(1, 1, 0, 0, 1, 4'd6);
    step(1, 1, 0, 0, 1, 4'd6);
    step(1, 1, 0, 1, 0, 4'd6);
    step(1, 1, 0, 1, 0, 4'd6);
    check_state("rev.lt2", 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 4'd6);
    check_state("rev.lt3", 0, 1, 0, 1);
    check("rev.peak", 32'(peak), 6);

    // 6. DEBOUNCE=1, CNT_W=2: every sample switches, counter saturates at 3.
    for (int i = 0; i < 6; i++) begin
      automatic logic up = (i % 2 == 0);
      automatic int   exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      step2(1, !up, up);
      check($sformatf("d1.%0d.high", i), 32'(high2), 32'(up));
      check($sformatf("d1.%0d.low", i),  32'(low2),  32'(!up));
      check($sformatf("d1.%0d.rise", i), 32'(rise2), 32'(up));
      check($sformatf("d1.%0d.fall", i), 32'(fall2), 32'(!up));
      check($sformatf("d1.%0d.cnt", i),  32'(evt_cnt2), 32'(exp_cnt));
    end
    step2(0, 0, 0);
    check("d1.idle.fall", 32'(fall2), 0);
    check("d1.idle.cnt",  32'(evt_cnt2), 3);
    check("d1.peak",      32'(peak2), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
